// File: rtl/soc_ctrl_pkg.sv
// Shared definitions for the SoC reset/watchdog sequencer: state encoding,
// reset-cause codes and a counter-width helper.
package soc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR    = 2'd0;
    localparam logic [1:0] CAUSE_BUTTON = 2'd1;
    localparam logic [1:0] CAUSE_WDT    = 2'd2;
    localparam logic [1:0] CAUSE_LOCK   = 2'd3;

    // A count of 1 still needs one bit of counter storage.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for an asynchronous
// push-button; the debounced level only follows after DEB_CYCLES stable cycles.
module btn_debounce
    import soc_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 65535,
    parameter bit INIT       = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level
);

    localparam int W = cnt_w(DEB_CYCLES);
    localparam logic [W-1:0] CNT_LAST = W'(DEB_CYCLES - 1);

    logic         r_sync1;
    logic         r_sync2;
    logic         r_level;
    logic [W-1:0] r_cnt;

    // Synchronizers reset to the released level so leaving reset never
    // looks like a fresh press.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= INIT;
            r_sync2 <= INIT;
            r_level <= INIT;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/soc_reset_ctrl.sv
// Reset and watchdog sequencer: holds soc_reset until PLL lock plus a hold
// time, re-enters reset on lock loss, button press or watchdog expiry.
module soc_reset_ctrl
    import soc_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 255,
    parameter int DEB_CYCLES  = 65535,
    parameter int WDT_CYCLES  = 1 << 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       btn_n,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       soc_reset,
    output logic [1:0] rst_cause,
    output logic       ready,
    output logic [1:0] dbg_state
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int WW = cnt_w(WDT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_CYCLES - 1);

    state_t        r_state;
    logic [1:0]    r_cause;
    logic [HW-1:0] r_hold_cnt;
    logic [WW-1:0] r_wdt_cnt;
    logic          r_lock_meta;
    logic          r_lock_s;
    logic          r_btn_prev;
    logic          w_btn_deb;
    logic          w_press;
    logic          w_wdt_expire;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .INIT      (1'b1)
    ) u_btn_debounce (
        .i_clk  (clk),
        .i_reset(reset),
        .i_btn  (btn_n),
        .o_level(w_btn_deb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_btn_prev  <= 1'b1;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
            r_btn_prev  <= w_btn_deb;
        end
    end

    // Edge tracking runs in every state, so a press seen outside RUN is
    // consumed there and never fires later.
    assign w_press = r_btn_prev & ~w_btn_deb;

    assign w_wdt_expire = (r_state == ST_RUN) && wdt_en && !wdt_kick &&
                          (r_wdt_cnt == WDT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdt_cnt <= '0;
        end else if ((r_state != ST_RUN) || !wdt_en || wdt_kick || w_wdt_expire) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WAIT_LOCK;
            r_cause    <= CAUSE_POR;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Lock loss outranks the button, which outranks the watchdog.
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cause <= CAUSE_LOCK;
                    end else if (w_press) begin
                        r_state    <= ST_HOLD;
                        r_cause    <= CAUSE_BUTTON;
                        r_hold_cnt <= '0;
                    end else if (w_wdt_expire) begin
                        r_state    <= ST_HOLD;
                        r_cause    <= CAUSE_WDT;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign soc_reset = (r_state != ST_RUN);
    assign ready     = (r_state == ST_RUN);
    assign rst_cause = r_cause;
    assign dbg_state = r_state;

endmodule
